// File: rtl/branch_resolve_ctrl.sv
// Decode-stage beq/bne resolver: stalls on operand hazards, compares, redirects the PC.
// Latency: branch resolved in cycle t -> pc_src/flush_if/jump_address valid in cycle t+1.
// Backpressure: drives o_stall_id combinationally while a branch operand is in flight.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_branch_valid/_ne        conditional branch present in ID, 1 = bne / 0 = beq
//   i_operand_hazard          rs or rt not yet forwardable
//   i_rs_value, i_rt_value    forwarded operands
//   i_branch_immediate        sign-extended word offset
//   i_pc_plus_four            branch address + 4
//   o_stall_id                freeze PC and IF/ID (combinational)
//   o_pc_src, o_flush_if      one-cycle redirect / squash (from state register)
//   o_jump_address            registered branch target
//   o_hazard_timeout          sticky stall watchdog flag
//   o_taken_count             saturating taken-branch counter
module branch_resolve_ctrl #(
  parameter int STALL_LIMIT = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_branch_valid,
  input  logic                   i_branch_ne,
  input  logic                   i_operand_hazard,
  input  logic [31:0]            i_rs_value,
  input  logic [31:0]            i_rt_value,
  input  logic [31:0]            i_branch_immediate,
  input  logic [31:0]            i_pc_plus_four,
  output logic                   o_stall_id,
  output logic                   o_pc_src,
  output logic [31:0]            o_jump_address,
  output logic                   o_flush_if,
  output logic                   o_hazard_timeout,
  output logic [COUNT_WIDTH-1:0] o_taken_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT     = 2'b01,
    S_REDIRECT = 2'b10
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [3:0]             LIMIT   = 4'(STALL_LIMIT);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [3:0]               r_stall_cnt;
  logic [3:0]               w_stall_cnt_nxt;
  logic [31:0]              r_jump_address;
  logic                     r_hazard_timeout;
  logic [COUNT_WIDTH-1:0]   r_taken_count;

  logic                     w_active;
  logic                     w_stall_req;
  logic                     w_resolve;
  logic                     w_taken;
  logic                     w_redirect_go;
  logic [31:0]              w_target;

  // REDIRECT is the only state that does not look at the ID instruction.
  assign w_active      = (r_state == S_IDLE) || (r_state == S_WAIT);
  assign w_stall_req   = i_branch_valid & i_operand_hazard;
  assign w_resolve     = w_active & i_branch_valid & ~i_operand_hazard;
  assign w_taken       = (i_rs_value == i_rt_value) ^ i_branch_ne;
  assign w_redirect_go = w_resolve & w_taken;
  // Word offset scaled to bytes; overflow past 2^32 wraps silently.
  assign w_target      = i_pc_plus_four + {i_branch_immediate[29:0], 2'b00};

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_stall_req)        w_next_state = S_WAIT;
        else if (w_redirect_go) w_next_state = S_REDIRECT;
        else                    w_next_state = S_IDLE;
      end
      S_WAIT: begin
        if (!i_branch_valid)    w_next_state = S_IDLE;   // cancelled upstream
        else if (w_stall_req)   w_next_state = S_WAIT;
        else if (w_taken)       w_next_state = S_REDIRECT;
        else                    w_next_state = S_IDLE;
      end
      S_REDIRECT: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_stall_id = i_rst_n & w_stall_req & w_active;
    o_pc_src   = (r_state == S_REDIRECT);
    o_flush_if = (r_state == S_REDIRECT);
  end

  // Consecutive-stall counter: 1 on the first stalled cycle, saturating at 15,
  // cleared whenever the branch resolves, is cancelled or we are redirecting.
  always_comb begin
    w_stall_cnt_nxt = 4'd0;
    if (w_active && w_stall_req) begin
      if (r_state == S_IDLE)       w_stall_cnt_nxt = 4'd1;
      else if (r_stall_cnt == 4'hF) w_stall_cnt_nxt = 4'hF;
      else                          w_stall_cnt_nxt = r_stall_cnt + 4'd1;
    end
  end

  // Datapath / debug registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt      <= 4'd0;
      r_jump_address   <= 32'd0;
      r_hazard_timeout <= 1'b0;
      r_taken_count    <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      // Watchdog only flags; it never forces the branch to resolve.
      if (w_active && w_stall_req && (w_stall_cnt_nxt >= LIMIT)) begin
        r_hazard_timeout <= 1'b1;
      end
      if (w_redirect_go) begin
        r_jump_address <= w_target;
        if (r_taken_count != CNT_MAX) begin
          r_taken_count <= r_taken_count + CNT_ONE;
        end
      end
    end
  end

  assign o_jump_address   = r_jump_address;
  assign o_hazard_timeout = r_hazard_timeout;
  assign o_taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vector table, then random vs. model.
// Latency: checks stall_id before each edge and registered outputs 1ns after it.
// Backpressure: stall_id is compared every cycle against the expected stall condition.
module tb_branch_resolve_ctrl;

  localparam int LIMIT = 3;
  localparam int CW    = 16;

  logic          clk;
  logic          rst_n;
  logic          bv, bne, hz;
  logic [31:0]   rs, rt, imm, pc4;
  logic          stall_id, pc_src, flush_if, hazard_timeout;
  logic [31:0]   jump_address;
  logic [CW-1:0] taken_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(.STALL_LIMIT(LIMIT), .COUNT_WIDTH(CW)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_branch_valid     (bv),
    .i_branch_ne        (bne),
    .i_operand_hazard   (hz),
    .i_rs_value         (rs),
    .i_rt_value         (rt),
    .i_branch_immediate (imm),
    .i_pc_plus_four     (pc4),
    .o_stall_id         (stall_id),
    .o_pc_src           (pc_src),
    .o_jump_address     (jump_address),
    .o_flush_if         (flush_if),
    .o_hazard_timeout   (hazard_timeout),
    .o_taken_count      (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, bv, bne, hz;
    logic [31:0] rs, rt, imm, pc4;
    logic        e_stall;      // before the edge
    logic        e_redir;      // pc_src and flush_if after the edge
    logic [31:0] e_jump;
    int          e_count;
    logic        e_to;
  } vec_t;

  vec_t vq[$];

  // Reference model: "redirecting" means the previous edge accepted a taken branch;
  // stall_run counts how many consecutive cycles the current branch has been held.
  logic        m_redirecting;
  int          m_stall_run;
  logic        m_timeout;
  int          m_count;
  logic [31:0] m_jump;

  function automatic logic m_stall_exp();
    return rst_n && bv && hz && !m_redirecting;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_redirecting = 0; m_stall_run = 0; m_timeout = 0; m_count = 0; m_jump = 0;
    end else if (m_redirecting) begin
      m_redirecting = 0;
      m_stall_run   = 0;
    end else if (bv && hz) begin
      m_stall_run = (m_stall_run >= 15) ? 15 : m_stall_run + 1;
      if (m_stall_run >= LIMIT) m_timeout = 1;
    end else if (bv) begin
      m_stall_run = 0;
      if ((rs == rt) != bne) begin
        m_redirecting = 1;
        m_jump        = pc4 + imm * 32'd4;
        if (m_count < (1 << CW) - 1) m_count = m_count + 1;
      end
    end else begin
      m_stall_run = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic n, input logic h,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                     input logic [31:0] p, input logic es, input logic er,
                     input logic [31:0] ej, input int ec, input logic et);
    vec_t x;
    x.rst_n = r; x.bv = v; x.bne = n; x.hz = h;
    x.rs = a; x.rt = b; x.imm = i; x.pc4 = p;
    x.e_stall = es; x.e_redir = er; x.e_jump = ej; x.e_count = ec; x.e_to = et;
    vq.push_back(x);
  endtask

  task automatic drive(input logic r, input logic v, input logic n, input logic h,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                       input logic [31:0] p);
    rst_n = r; bv = v; bne = n; hz = h; rs = a; rt = b; imm = i; pc4 = p;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_redirecting = 0; m_stall_run = 0; m_timeout = 0; m_count = 0; m_jump = 0;

    //  rst v  ne hz rs  rt  imm           pc4           stall redir jump          cnt to
    add(0, 0, 0, 0, 0,  0,  0,            0,            0,    0,    32'h0,        0,  0); // reset
    add(0, 1, 0, 1, 0,  1,  0,            0,            0,    0,    32'h0,        0,  0); // stall forced low
    add(1, 1, 0, 0, 5,  5,  32'h3,        32'h100,      0,    1,    32'h10C,      1,  0); // beq taken
    add(1, 0, 0, 0, 0,  0,  0,            0,            0,    0,    32'h10C,      1,  0); // redirect ends
    add(1, 1, 1, 0, 7,  7,  32'h40,       32'h200,      0,    0,    32'h10C,      1,  0); // bne not taken
    add(1, 1, 0, 0, 1,  2,  32'h40,       32'h200,      0,    0,    32'h10C,      1,  0); // beq not taken
    add(1, 1, 0, 0, 4,  4,  32'hFFFFFFFE, 32'h100,      0,    1,    32'hF8,       2,  0); // negative offset
    add(1, 1, 0, 1, 4,  4,  32'h1,        32'hFFFFFFFC, 0,    0,    32'hF8,       2,  0); // ignored in REDIRECT
    add(1, 1, 0, 0, 4,  4,  32'h1,        32'hFFFFFFFC, 0,    1,    32'h0,        3,  0); // back-to-back, wrap
    add(1, 0, 0, 0, 0,  0,  0,            0,            0,    0,    32'h0,        3,  0);
    add(1, 1, 0, 1, 9,  9,  32'h4,        32'h200,      1,    0,    32'h0,        3,  0); // hazard 1
    add(1, 1, 0, 1, 9,  9,  32'h4,        32'h200,      1,    0,    32'h0,        3,  0); // hazard 2
    add(1, 1, 0, 0, 9,  9,  32'h4,        32'h200,      0,    1,    32'h210,      4,  0); // resolve
    add(1, 0, 0, 0, 0,  0,  0,            0,            0,    0,    32'h210,      4,  0);
    add(1, 1, 0, 1, 0,  1,  32'h4,        32'h300,      1,    0,    32'h210,      4,  0); // watchdog run
    add(1, 1, 0, 1, 0,  1,  32'h4,        32'h300,      1,    0,    32'h210,      4,  0);
    add(1, 1, 0, 1, 0,  1,  32'h4,        32'h300,      1,    0,    32'h210,      4,  1); // 3rd WAIT: flag
    add(1, 1, 0, 1, 0,  1,  32'h4,        32'h300,      1,    0,    32'h210,      4,  1);
    add(1, 0, 0, 0, 0,  1,  32'h4,        32'h300,      0,    0,    32'h210,      4,  1); // cancel
    add(1, 0, 0, 0, 0,  0,  0,            0,            0,    0,    32'h210,      4,  1);
    add(0, 1, 0, 0, 3,  3,  32'h8,        32'h40,       0,    0,    32'h0,        0,  0); // reset on resolve
    add(1, 1, 0, 1, 3,  3,  32'h8,        32'h40,       1,    0,    32'h0,        0,  0); // enter WAIT
    add(0, 1, 0, 1, 3,  3,  32'h8,        32'h40,       0,    0,    32'h0,        0,  0); // reset in WAIT
    add(1, 0, 0, 0, 0,  0,  0,            0,            0,    0,    32'h0,        0,  0); // no redirect after

    @(negedge clk);
    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].rst_n, vq[k].bv, vq[k].bne, vq[k].hz, vq[k].rs, vq[k].rt, vq[k].imm, vq[k].pc4);
      #1;
      check($sformatf("v%0d stall_id", k), {31'd0, stall_id}, {31'd0, vq[k].e_stall});
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("v%0d pc_src", k),   {31'd0, pc_src},   {31'd0, vq[k].e_redir});
      check($sformatf("v%0d flush_if", k), {31'd0, flush_if}, {31'd0, vq[k].e_redir});
      check($sformatf("v%0d jump", k),     jump_address,      vq[k].e_jump);
      check($sformatf("v%0d count", k),    32'(taken_count),  32'(vq[k].e_count));
      check($sformatf("v%0d timeout", k),  {31'd0, hazard_timeout}, {31'd0, vq[k].e_to});
      @(negedge clk);
    end

    // Randomized phase against the model; the table ended in reset so both agree.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      a = $urandom_range(0, 3);
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 9) < 7), 1'($urandom),
            ($urandom_range(0, 9) < 4), a, b, $urandom, $urandom);
      #1;
      check("rnd stall_id", {31'd0, stall_id}, {31'd0, m_stall_exp()});
      @(posedge clk);
      model_edge();
      #1;
      check("rnd pc_src",   {31'd0, pc_src},         {31'd0, m_redirecting});
      check("rnd flush_if", {31'd0, flush_if},       {31'd0, m_redirecting});
      check("rnd jump",     jump_address,            m_jump);
      check("rnd count",    32'(taken_count),        32'(m_count));
      check("rnd timeout",  {31'd0, hazard_timeout}, {31'd0, m_timeout});
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Decode-stage branch controller for the pipelined MIPS core.
- Sequences beq/bne resolution in ID:
  - stalls IF/ID while a branch operand is still in flight;
  - compares the operands;
  - forms the target as pc_plus_four + (sign-extended immediate << 2);
  - issues a one-cycle PC redirect plus IF flush.
- Also keeps a taken-branch counter and a sticky hazard-watchdog flag for debug.

Parameters:
STALL_LIMIT, 3, number of consecutive WAIT cycles after which hazard_timeout is set (1..15)
COUNT_WIDTH, 16, width of taken_count

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
branch_valid  input  1  ID stage holds a conditional branch
branch_ne  input  1  1 = bne, 0 = beq; sampled with branch_valid
operand_hazard  input  1  rs or rt is not yet forwardable (EX/MEM producer pending)
rs_value  input  32  forwarded rs operand
rt_value  input  32  forwarded rt operand
branch_immediate  input  32  sign-extended branch immediate (word offset)
pc_plus_four  input  32  address of branch + 4
stall_id  output  1  freeze PC and IF/ID register (combinational)
pc_src  output  1  1 = PC mux selects jump_address (registered)
jump_address  output  32  registered branch target
flush_if  output  1  squash IF/ID contents (registered)
hazard_timeout  output  1  sticky watchdog flag
taken_count  output  COUNT_WIDTH  saturating count of taken branches

Behaviour:
- Reset: sampled only on a clk edge with rst_n=0 (synchronous, active-low).
  - Reset values: state=IDLE, jump_address=0, pc_src=0, flush_if=0, hazard_timeout=0, taken_count=0, stall counter=0.
  - stall_id is forced to 0 while rst_n=0.
  - Reset in any state aborts the operation in progress; no redirect follows.
- FSM states: IDLE, WAIT, REDIRECT.
- stall_id = rst_n & branch_valid & operand_hazard & (state==IDLE | state==WAIT). Same-cycle, not registered.
- Resolve condition: (state==IDLE | state==WAIT) & branch_valid & !operand_hazard.
  - taken = (rs_value==rt_value) XOR branch_ne (full 32-bit compare).
- IDLE:
  - branch_valid & operand_hazard -> WAIT; stall counter is set to 1.
  - Resolve & taken -> REDIRECT.
    - Register jump_address = pc_plus_four + {branch_immediate[29:0],2'b00}, modulo 2^32; wrap-around is silent.
    - Increment taken_count, saturating at all-ones.
  - Resolve & !taken -> stay IDLE; no outputs change.
- WAIT:
  - branch_valid & operand_hazard -> stay WAIT.
    - Stall counter increments, saturating at 15.
    - When the counter reaches STALL_LIMIT, set hazard_timeout. It stays 1 until reset.
    - Stalling continues; the watchdog never forces resolution.
  - Resolve -> same actions as IDLE resolve; the not-taken case returns to IDLE.
  - branch_valid=0 (branch cancelled upstream) -> IDLE; counter cleared; no redirect.
- REDIRECT: lasts exactly 1 cycle.
  - pc_src=1 and flush_if=1 during this cycle only.
  - branch_valid is ignored here; the instruction in ID is wrong-path.
  - Unconditionally -> IDLE; pc_src and flush_if return to 0 the next cycle.
- Latency: branch resolved in cycle t -> pc_src/flush_if/jump_address valid in cycle t+1.
  - jump_address holds its value until the next taken resolution.
- Back-to-back: a branch presented in the cycle immediately after REDIRECT is handled normally from IDLE.

Test Plan:
- Taken, no hazard: beq, rs=rt=5, imm=0x3, pc4=0x100 -> next cycle pc_src=1, flush_if=1, jump_address=0x10C for exactly 1 cycle; stall_id never 1; taken_count=1.
- Not taken: bne, rs=rt=7 -> pc_src, flush_if, stall_id all stay 0; taken_count unchanged. Repeat with beq, rs=1, rt=2 -> same result.
- Negative offset and wrap:
  - imm=0xFFFFFFFE, pc4=0x100, taken -> jump_address=0xF8.
  - imm=0x1, pc4=0xFFFFFFFC, taken -> jump_address=0x00000000.
- Hazard stall: beq equal with operand_hazard=1 for 2 cycles, then 0 -> stall_id=1 for those 2 cycles, 0 on the resolve cycle; redirect the next cycle; hazard_timeout stays 0.
- Watchdog and cancel:
  - operand_hazard held for 4 cycles with STALL_LIMIT=3 -> hazard_timeout rises on the 3rd WAIT cycle and stays high.
  - Then drop branch_valid -> IDLE, stall_id=0, no redirect.
- Reset mid-operation:
  - rst_n=0 on the edge ending the resolve cycle -> following cycle pc_src=0, flush_if=0, taken_count=0, jump_address=0.
  - rst_n=0 during WAIT -> stall_id=0 immediately.
